bpsk_frame_sync: RTL and testbench

Frame synchronizer and byte packer directly downstream of the BPSK hard-decision demapper. It consumes the demapper's one-bit-per-valid stream (`valid_x`/`x`), hunts for a fixed sync word in either polarity, which resolves the BPSK 180° phase ambiguity, and emits a fixed-length payload as bytes with start/end-of-frame flags. It then returns to hunting for the next frame.

---
 rtl/bpsk_frame_sync.sv | 132 +++++++++++++
 tb/tb_bpsk_frame_sync.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_sync.sv
// BPSK frame sync: hunts a sync word in either polarity, then packs a fixed payload into bytes (MSB first).
// Latency: each byte is registered on the edge sampling its 8th valid bit; no backpressure, valid_x gaps simply stall all state.
module bpsk_frame_sync #(
  parameter logic [31:0] SYNC_WORD     = 32'h0000F0A5,
  parameter int          SYNC_LEN      = 16,
  parameter int          PAYLOAD_BYTES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       valid_x,
  input  logic       x,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       sof,
  output logic       eof,
  output logic       locked,
  output logic       inv
);

  localparam int                   FW        = $clog2(SYNC_LEN + 1);
  localparam logic [SYNC_LEN-1:0]  SW        = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [FW-1:0]        FILL_MAX  = FW'(SYNC_LEN);
  localparam logic [FW-1:0]        FILL_ARM  = FW'(SYNC_LEN - 1);
  localparam logic [7:0]           LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic [SYNC_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                inv_q, inv_d;
  logic                valid_d, sof_d, eof_d;
  logic [7:0]          data_d;

  logic [SYNC_LEN-1:0] cand;
  logic [7:0]          byte_w;

  // Window including the bit currently presented, so the match lands on the edge that samples it.
  assign cand   = {hist_q[SYNC_LEN-2:0], x};
  assign byte_w = {shreg_q[6:0], x ^ inv_q};

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    inv_d      = inv_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    data_d     = data_o;

    if (valid_x) begin
      hist_d = cand;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end

      case (state_q)
        HUNT: begin
          if (fill_q >= FILL_ARM) begin
            if (cand == SW) begin
              state_d = PAYLOAD;
              inv_d   = 1'b0;
            end else if (cand == ~SW) begin
              state_d = PAYLOAD;
              inv_d   = 1'b1;
            end
          end
        end

        PAYLOAD: begin
          shreg_d   = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            valid_d    = 1'b1;
            data_d     = byte_w;
            sof_d      = (byte_cnt_q == 8'd0);
            eof_d      = (byte_cnt_q == LAST_BYTE);
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q == LAST_BYTE) begin
              // Frame done: next sync must be built from fresh bits only.
              state_d    = HUNT;
              fill_d     = '0;
              bit_cnt_d  = 3'd0;
              byte_cnt_d = 8'd0;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      shreg_q    <= 8'd0;
      inv_q      <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= 8'h00;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      inv_q      <= inv_d;
      valid_o    <= valid_d;
      data_o     <= data_d;
      sof        <= sof_d;
      eof        <= eof_d;
    end
  end

  assign locked = (state_q == PAYLOAD);
  assign inv    = inv_q;

endmodule

// File: tb/tb_bpsk_frame_sync.sv
// Bench for bpsk_frame_sync: directed and randomized bit streams checked against a window-search reference model.
module tb_bpsk_frame_sync;
  localparam int          SL = 16;
  localparam logic [15:0] SW = 16'hF0A5;
  localparam int          PB = 4;

  logic       CLK;
  logic       RST;
  logic       valid_x;
  logic       x;
  logic       valid_o;
  logic [7:0] data_o;
  logic       sof;
  logic       eof;
  logic       locked;
  logic       inv;

  bpsk_frame_sync #(
    .SYNC_WORD     (32'h0000F0A5),
    .SYNC_LEN      (SL),
    .PAYLOAD_BYTES (PB)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .valid_x (valid_x),
    .x       (x),
    .valid_o (valid_o),
    .data_o  (data_o),
    .sof     (sof),
    .eof     (eof),
    .locked  (locked),
    .inv     (inv)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         idx;
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       inv;
    logic       pv;
  } ev_t;

  typedef struct {
    int   idx;
    logic val;
  } lk_t;

  ev_t  obs_ev[$];
  lk_t  obs_lk[$];
  int   nbits = 0;
  logic last_vld = 1'b0;
  logic prev_locked = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // nbits = valid bits consumed by the DUT so far; last_vld = valid_x at the latest edge.
  always @(posedge CLK) begin
    last_vld <= valid_x;
    if (RST === 1'b1 && valid_x === 1'b1) nbits <= nbits + 1;
  end

  always @(negedge CLK) begin
    if (valid_o === 1'b1) obs_ev.push_back('{nbits, data_o, sof, eof, inv, last_vld});
    if (locked !== prev_locked) begin
      obs_lk.push_back('{nbits, locked});
      prev_locked = locked;
    end
  end

  // Reference: scan the bit list for the first full sync window (either polarity)
  // starting SYNC_LEN-1 bits after the end of the previous frame, then slice bytes.
  function automatic void model(input bit b[$], output ev_t e[$], output lk_t l[$]);
    int          n;
    int          start;
    int          s;
    logic        iv;
    logic [15:0] w;
    logic [7:0]  by;
    n = b.size();
    start = 0;
    iv = 1'b0;
    e.delete();
    l.delete();
    while (1) begin
      s = -1;
      for (int i = start + SL - 1; i < n; i++) begin
        w = '0;
        for (int j = 0; j < SL; j++) w = {w[14:0], b[i-SL+1+j]};
        if (w == SW) begin s = i; iv = 1'b0; break; end
        if (w == ~SW) begin s = i; iv = 1'b1; break; end
      end
      if (s < 0) break;
      l.push_back('{s + 1, 1'b1});
      for (int k = 0; k < PB; k++) begin
        if (s + 8*(k+1) >= n) break;
        by = '0;
        for (int j = 1; j <= 8; j++) by = {by[6:0], logic'(b[s+8*k+j]) ^ iv};
        e.push_back('{s + 1 + 8*(k+1), by, k == 0, k == PB-1, iv, 1'b1});
      end
      if (s + 8*PB >= n) break;
      l.push_back('{s + 1 + 8*PB, 1'b0});
      start = s + 1 + 8*PB;
    end
  endfunction

  function automatic void push_bits(inout bit q[$], input logic [31:0] v, input int n, input logic flip);
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i] ^ flip);
  endfunction

  // mode 0: continuous, 1: idle after every bit, 2: 20 idle cycles after bit gap_at, 3: random idles
  task automatic drive(input bit b[$], input int mode, input int gap_at);
    int idle;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge CLK);
      valid_x = 1'b1;
      x = b[i];
      idle = 0;
      if (mode == 1) idle = 1;
      if (mode == 2 && i == gap_at) idle = 20;
      if (mode == 3) idle = $urandom_range(0, 3);
      repeat (idle) begin
        @(negedge CLK);
        valid_x = 1'b0;
        x = 1'($urandom_range(0, 1));
      end
    end
    @(negedge CLK);
    valid_x = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors += 6;
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid_o got %b want 0", valid_o); end
    if (data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data_o got %h want 00", data_o); end
    if (sof !== 1'b0) begin miscompares++; $display("FAIL reset_sof got %b want 0", sof); end
    if (eof !== 1'b0) begin miscompares++; $display("FAIL reset_eof got %b want 0", eof); end
    if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
    if (inv !== 1'b0) begin miscompares++; $display("FAIL reset_inv got %b want 0", inv); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_polarity(input logic flip);
    bit         b[$];
    ev_t        e[$];
    lk_t        l[$];
    ev_t        o;
    int         base, eb, lb;
    logic [7:0] want [4];
    want = '{8'h12, 8'h34, 8'h56, 8'h78};
    apply_reset();
    base = nbits; eb = obs_ev.size(); lb = obs_lk.size();
    push_bits(b, 32'h0000F0A5, 16, flip);
    push_bits(b, 32'h12345678, 32, flip);
    model(b, e, l);
    drive(b, 0, 0);
    vectors++;
    if (obs_ev.size() - eb != 4) begin
      miscompares++; $display("FAIL pol%0b_nbytes got %0d want 4", flip, obs_ev.size() - eb);
    end
    for (int k = 0; k < 4 && eb + k < obs_ev.size(); k++) begin
      o = obs_ev[eb+k];
      vectors++;
      if (o.dat !== want[k] || o.idx - base != 24 + 8*k || o.sof !== (k == 0) || o.eof !== (k == 3) || o.inv !== flip) begin
        miscompares++;
        $display("FAIL pol%0b_byte%0d got dat=%h idx=%0d sof=%b eof=%b inv=%b want dat=%h idx=%0d sof=%b eof=%b inv=%b",
                 flip, k, o.dat, o.idx - base, o.sof, o.eof, o.inv, want[k], 24 + 8*k, k == 0, k == 3, flip);
      end
      vectors++;
      if (k < e.size() && (o.dat !== e[k].dat || o.idx - base != e[k].idx || o.pv !== 1'b1)) begin
        miscompares++;
        $display("FAIL pol%0b_model%0d got dat=%h idx=%0d pv=%b want dat=%h idx=%0d pv=1", flip, k, o.dat, o.idx - base, o.pv, e[k].dat, e[k].idx);
      end
    end
    vectors++;
    if (obs_lk.size() - lb != 2 || obs_lk[lb].idx - base != 16 || obs_lk[lb+1].idx - base != 48 || obs_lk[lb+1].val !== 1'b0) begin
      miscompares++; $display("FAIL pol%0b_locked got %0d edges want rise@16 fall@48", flip, obs_lk.size() - lb);
    end
    vectors++;
    if (data_o !== 8'h78 || inv !== flip) begin
      miscompares++; $display("FAIL pol%0b_hold got data_o=%h inv=%b want 78 %b", flip, data_o, inv, flip);
    end
  endtask

  task automatic test_random_lead();
    bit         b[$];
    ev_t        e[$];
    lk_t        l[$];
    ev_t        o;
    int         base, eb, tries;
    logic       flip;
    logic [31:0] pay;
    tries = 0;
    do begin
      b.delete();
      for (int i = 0; i < 37; i++) b.push_back(1'($urandom_range(0, 1)));
      flip = 1'($urandom_range(0, 1));
      pay = $urandom();
      push_bits(b, 32'h0000F0A5, 16, flip);
      push_bits(b, pay, 32, 1'b0);
      model(b, e, l);
      tries++;
    end while ((l.size() == 0 || l[0].idx != 53) && tries < 200);
    apply_reset();
    base = nbits; eb = obs_ev.size();
    drive(b, 0, 0);
    vectors++;
    if (obs_ev.size() - eb != 4) begin
      miscompares++; $display("FAIL lead_nbytes got %0d want 4", obs_ev.size() - eb);
    end
    for (int k = 0; k < 4 && eb + k < obs_ev.size(); k++) begin
      o = obs_ev[eb+k];
      vectors++;
      if (o.dat !== (pay[31-8*k -: 8] ^ {8{flip}}) || o.idx - base != 53 + 8*(k+1) || o.inv !== flip || o.sof !== (k == 0) || o.eof !== (k == 3)) begin
        miscompares++;
        $display("FAIL lead_byte%0d got dat=%h idx=%0d inv=%b sof=%b eof=%b want dat=%h idx=%0d inv=%b",
                 k, o.dat, o.idx - base, o.inv, o.sof, o.eof, pay[31-8*k -: 8] ^ {8{flip}}, 53 + 8*(k+1), flip);
      end
    end
  endtask

  task automatic test_gaps();
    bit  b[$];
    ev_t e[$];
    lk_t l[$];
    ev_t o;
    int  base, eb;
    push_bits(b, 32'h0000F0A5, 16, 1'b0);
    push_bits(b, 32'h12345678, 32, 1'b0);
    model(b, e, l);
    for (int m = 1; m <= 2; m++) begin
      apply_reset();
      base = nbits; eb = obs_ev.size();
      drive(b, m, 19);
      vectors++;
      if (obs_ev.size() - eb != e.size()) begin
        miscompares++; $display("FAIL gaps_m%0d_nbytes got %0d want %0d", m, obs_ev.size() - eb, e.size());
      end
      for (int k = 0; k < e.size() && eb + k < obs_ev.size(); k++) begin
        o = obs_ev[eb+k];
        vectors++;
        if (o.idx - base != e[k].idx || o.dat !== e[k].dat || o.sof !== e[k].sof || o.eof !== e[k].eof || o.inv !== e[k].inv || o.pv !== 1'b1) begin
          miscompares++;
          $display("FAIL gaps_m%0d_byte%0d got idx=%0d dat=%h sof=%b eof=%b inv=%b pv=%b want idx=%0d dat=%h sof=%b eof=%b inv=%b pv=1",
                   m, k, o.idx - base, o.dat, o.sof, o.eof, o.inv, o.pv, e[k].idx, e[k].dat, e[k].sof, e[k].eof, e[k].inv);
        end
      end
    end
  endtask

  task automatic test_embedded_sync();
    bit          b[$];
    ev_t         e[$];
    lk_t         l[$];
    ev_t         o;
    int          base, eb, lb;
    logic [31:0] pay2;
    logic [7:0]  want1 [4];
    want1 = '{8'hF0, 8'hA5, 8'hC3, 8'hD5};
    pay2 = $urandom();
    push_bits(b, 32'h0000F0A5, 16, 1'b0);
    push_bits(b, 32'hF0A5C3D5, 32, 1'b0);
    push_bits(b, 32'h0000F0A5, 16, 1'b1);
    push_bits(b, pay2, 32, 1'b0);
    model(b, e, l);
    apply_reset();
    base = nbits; eb = obs_ev.size(); lb = obs_lk.size();
    drive(b, 0, 0);
    vectors++;
    if (obs_ev.size() - eb != 8) begin
      miscompares++; $display("FAIL embed_nbytes got %0d want 8", obs_ev.size() - eb);
    end
    for (int k = 0; k < 8 && eb + k < obs_ev.size(); k++) begin
      o = obs_ev[eb+k];
      vectors++;
      if ((k < 4 && o.dat !== want1[k]) || (k >= 4 && o.dat !== (pay2[31-8*(k-4) -: 8] ^ 8'hFF))) begin
        miscompares++; $display("FAIL embed_byte%0d got %h want frame byte %0d", k, o.dat, k);
      end
      vectors++;
      if (k < e.size() && (o.idx - base != e[k].idx || o.sof !== e[k].sof || o.eof !== e[k].eof || o.inv !== e[k].inv)) begin
        miscompares++;
        $display("FAIL embed_model%0d got idx=%0d sof=%b eof=%b inv=%b want idx=%0d sof=%b eof=%b inv=%b",
                 k, o.idx - base, o.sof, o.eof, o.inv, e[k].idx, e[k].sof, e[k].eof, e[k].inv);
      end
    end
    vectors++;
    if (obs_lk.size() - lb != 4 || obs_lk[lb+2].idx - base != 64) begin
      miscompares++; $display("FAIL embed_relock got %0d lock edges want 4 with second rise at 64", obs_lk.size() - lb);
    end
  endtask

  task automatic test_back_to_back();
    bit  b[$];
    ev_t e[$];
    lk_t l[$];
    ev_t o;
    int  base, eb, lb;
    for (int it = 0; it < 6; it++) begin
      b.delete();
      for (int f = 0; f < 3; f++) begin
        repeat ($urandom_range(0, 20)) b.push_back(1'($urandom_range(0, 1)));
        push_bits(b, 32'h0000F0A5, 16, 1'($urandom_range(0, 1)));
        push_bits(b, $urandom(), 32, 1'b0);
      end
      model(b, e, l);
      apply_reset();
      base = nbits; eb = obs_ev.size(); lb = obs_lk.size();
      drive(b, 3, 0);
      vectors++;
      if (obs_ev.size() - eb != e.size()) begin
        miscompares++; $display("FAIL b2b%0d_nbytes got %0d want %0d", it, obs_ev.size() - eb, e.size());
      end
      for (int k = 0; k < e.size() && eb + k < obs_ev.size(); k++) begin
        o = obs_ev[eb+k];
        vectors++;
        if (o.idx - base != e[k].idx || o.dat !== e[k].dat || o.sof !== e[k].sof || o.eof !== e[k].eof || o.inv !== e[k].inv || o.pv !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b%0d_byte%0d got idx=%0d dat=%h sof=%b eof=%b inv=%b pv=%b want idx=%0d dat=%h sof=%b eof=%b inv=%b pv=1",
                   it, k, o.idx - base, o.dat, o.sof, o.eof, o.inv, o.pv, e[k].idx, e[k].dat, e[k].sof, e[k].eof, e[k].inv);
        end
      end
      vectors++;
      if (obs_lk.size() - lb != l.size()) begin
        miscompares++; $display("FAIL b2b%0d_lock_edges got %0d want %0d", it, obs_lk.size() - lb, l.size());
      end
      for (int k = 0; k < l.size() && lb + k < obs_lk.size(); k++) begin
        vectors++;
        if (obs_lk[lb+k].idx - base != l[k].idx || obs_lk[lb+k].val !== l[k].val) begin
          miscompares++;
          $display("FAIL b2b%0d_lock%0d got idx=%0d val=%b want idx=%0d val=%b",
                   it, k, obs_lk[lb+k].idx - base, obs_lk[lb+k].val, l[k].idx, l[k].val);
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit          b[$];
    ev_t         e[$];
    lk_t         l[$];
    ev_t         o;
    int          base, eb;
    logic [31:0] pay;
    apply_reset();
    eb = obs_ev.size();
    push_bits(b, 32'h0000F0A5, 16, 1'b1);
    push_bits(b, 32'h0000A7C3, 16, 1'b1);
    push_bits(b, 32'h00000005, 3, 1'b0);
    drive(b, 0, 0);
    vectors++;
    if (obs_ev.size() - eb != 2 || locked !== 1'b1 || inv !== 1'b1 || data_o !== 8'hC3) begin
      miscompares++;
      $display("FAIL mrst_pre got bytes=%0d locked=%b inv=%b data_o=%h want 2 1 1 c3", obs_ev.size() - eb, locked, inv, data_o);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || sof !== 1'b0 || eof !== 1'b0 || locked !== 1'b0 || inv !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_outputs got valid_o=%b data_o=%h sof=%b eof=%b locked=%b inv=%b want all 0",
               valid_o, data_o, sof, eof, locked, inv);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (obs_ev.size() - eb != 2) begin
      miscompares++; $display("FAIL mrst_no_eof got %0d bytes want 2", obs_ev.size() - eb);
    end
    b.delete();
    pay = $urandom();
    push_bits(b, 32'h0000F0A5, 16, 1'b0);
    push_bits(b, pay, 32, 1'b0);
    model(b, e, l);
    base = nbits; eb = obs_ev.size();
    drive(b, 0, 0);
    vectors++;
    if (obs_ev.size() - eb != 4) begin
      miscompares++; $display("FAIL mrst_after_nbytes got %0d want 4", obs_ev.size() - eb);
    end
    for (int k = 0; k < e.size() && eb + k < obs_ev.size(); k++) begin
      o = obs_ev[eb+k];
      vectors++;
      if (o.idx - base != e[k].idx || o.dat !== e[k].dat || o.sof !== e[k].sof || o.eof !== e[k].eof || o.inv !== 1'b0) begin
        miscompares++;
        $display("FAIL mrst_after_byte%0d got idx=%0d dat=%h sof=%b eof=%b inv=%b want idx=%0d dat=%h sof=%b eof=%b inv=0",
                 k, o.idx - base, o.dat, o.sof, o.eof, o.inv, e[k].idx, e[k].dat, e[k].sof, e[k].eof);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    valid_x = 1'b0;
    x = 1'b0;
    test_reset();
    test_polarity(1'b0);
    test_polarity(1'b1);
    test_random_lead();
    test_gaps();
    test_embedded_sync();
    test_back_to_back();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
